// File: rtl/stack_sequencer_pkg.sv
// Shared opcode, FSM-state and operand-count definitions for the stack sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package stack_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_PUSH = 3'b000,
        OP_POP  = 3'b001,
        OP_DUP  = 3'b010,
        OP_ADD  = 3'b011,
        OP_SUB  = 3'b100,
        OP_AND  = 3'b101,
        OP_OR   = 3'b110,
        OP_NOT  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ_A   = 3'd1,
        S_CAP_A    = 3'd2,
        S_READ_B   = 3'd3,
        S_CAP_B    = 3'd4,
        S_PUSH_R   = 3'd5,
        S_POP_ONLY = 3'd6
    } state_e;

    // Number of stack entries an op consumes as operands.
    function automatic logic [1:0] operands_needed(op_e op);
        case (op)
            OP_PUSH:                operands_needed = 2'd0;
            OP_POP, OP_DUP, OP_NOT: operands_needed = 2'd1;
            default:                operands_needed = 2'd2;
        endcase
    endfunction

    // Net change in stack depth once the op completes.
    function automatic logic signed [1:0] depth_delta(op_e op);
        case (op)
            OP_PUSH, OP_DUP: depth_delta = 2'sd1;
            OP_NOT:          depth_delta = 2'sd0;
            default:         depth_delta = -2'sd1;
        endcase
    endfunction

    function automatic logic is_binary(op_e op);
        is_binary = (operands_needed(op) == 2'd2);
    endfunction

endpackage

// File: rtl/stack_alu.sv
// Computes the value pushed back by an op from a (top), b (below top) and the immediate.
// Latency: combinational.
// Backpressure: none.
module stack_alu
    import stack_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] y
);

    // Select the op's value; carries and borrows fall off the top.
    always_comb begin
        y = '0;
        case (op)
            OP_PUSH: y = imm;
            OP_POP:  y = a;
            OP_DUP:  y = a;
            OP_ADD:  y = b + a;
            OP_SUB:  y = b - a;
            OP_AND:  y = b & a;
            OP_OR:   y = b | a;
            OP_NOT:  y = ~a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/stack_sequencer.sv
// Sequences stack strobes to execute one stack-machine command at a time.
// Latency: done at T+2 (PUSH), T+3 (POP), T+4 (DUP/NOT), T+6 (binary), T+1 (rejected).
// Backpressure: cmd_ready only in IDLE; a new command may be accepted in the done cycle.
module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    input  logic [2:0]               cmd_op,
    input  logic [WIDTH-1:0]         cmd_imm,
    output logic                     cmd_ready,
    output logic                     done,
    output logic                     err,
    output logic [WIDTH-1:0]         result,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     stk_push,
    output logic                     stk_pop,
    output logic                     stk_tos,
    output logic [WIDTH-1:0]         stk_din,
    input  logic [WIDTH-1:0]         stk_dout
);

    localparam int DW = $clog2(DEPTH) + 1;
    localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);

    state_e           state_q, state_d;
    op_e              op_q;
    logic [WIDTH-1:0] imm_q, a_q, b_q, result_q, alu_y;
    logic [DW-1:0]    depth_q;
    logic             done_q, err_q;

    op_e  cmd_op_e;
    logic accept, underflow, overflow, reject;

    assign cmd_op_e  = op_e'(cmd_op);
    assign accept    = cmd_valid && (state_q == S_IDLE);
    assign underflow = int'(depth_q) < int'(operands_needed(cmd_op_e));
    assign overflow  = (depth_delta(cmd_op_e) == 2'sd1) && (depth_q == DEPTH_FULL);
    assign reject    = underflow || overflow;

    stack_alu #(.WIDTH(WIDTH)) u_alu (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .imm (imm_q),
        .y   (alu_y)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: walk the op's read/capture/write sequence, rejected commands stay in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && !reject)
                    state_d = (cmd_op_e == OP_PUSH) ? S_PUSH_R : S_READ_A;
            end
            S_READ_A:   state_d = (op_q == OP_POP) ? S_POP_ONLY : S_CAP_A;
            S_CAP_A:    state_d = is_binary(op_q) ? S_READ_B : S_PUSH_R;
            S_READ_B:   state_d = S_CAP_B;
            S_CAP_B:    state_d = S_PUSH_R;
            S_PUSH_R:   state_d = S_IDLE;
            S_POP_ONLY: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; strobes are mutually exclusive by construction.
    always_comb begin
        cmd_ready = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_tos   = 1'b0;
        stk_din   = '0;
        case (state_q)
            S_IDLE:     cmd_ready = 1'b1;
            S_READ_A:   stk_tos   = 1'b1;
            S_CAP_A:    stk_pop   = (op_q != OP_DUP);
            S_READ_B:   stk_tos   = 1'b1;
            S_CAP_B:    stk_pop   = 1'b1;
            S_POP_ONLY: stk_pop   = 1'b1;
            S_PUSH_R: begin
                stk_push = 1'b1;
                stk_din  = alu_y;
            end
            default: ;
        endcase
    end

    // Datapath: latch the command, capture operands, track depth and flag completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= OP_PUSH;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            depth_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= (state_q == S_PUSH_R) || (state_q == S_POP_ONLY) || (accept && reject);
            err_q  <= accept && reject;
            if (accept) begin
                op_q  <= cmd_op_e;
                imm_q <= cmd_imm;
            end
            if (state_q == S_CAP_A)    a_q      <= stk_dout;
            if (state_q == S_CAP_B)    b_q      <= stk_dout;
            if (state_q == S_POP_ONLY) result_q <= stk_dout;
            if (state_q == S_PUSH_R)   result_q <= alu_y;
            if (stk_push && depth_q != DEPTH_FULL)
                depth_q <= depth_q + 1'b1;
            else if (stk_pop && depth_q != '0)
                depth_q <= depth_q - 1'b1;
        end
    end

    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
    assign depth  = depth_q;

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;

    logic       clk, rst_n;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [7:0] cmd_imm;
    logic       cmd_ready, done, err;
    logic [7:0] result;
    logic [3:0] depth;
    logic       stk_push, stk_pop, stk_tos;
    logic [7:0] stk_din, stk_dout;

    stack_sequencer #(.WIDTH(8), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_imm(cmd_imm),
        .cmd_ready(cmd_ready), .done(done), .err(err), .result(result), .depth(depth),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_tos(stk_tos), .stk_din(stk_din),
        .stk_dout(stk_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hardware stack model: registered read one cycle after tos.
    logic [7:0] mem [8];
    int         sp;
    always @(posedge clk) begin
        if (!rst_n) sp <= 0;
        else begin
            if (stk_push && sp < 8) begin mem[sp] <= stk_din; sp <= sp + 1; end
            if (stk_pop && sp > 0) sp <= sp - 1;
            if (stk_tos && sp > 0) stk_dout <= mem[sp-1];
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    // Observations from the last command.
    int          obs_lat, obs_cnt;
    logic        obs_err, obs_bad;
    logic [7:0]  obs_pdin;
    logic [23:0] obs_trace;

    // Reference model state and expectations.
    logic [7:0] ref_stk[$];
    logic [7:0] ref_result;
    logic       exp_err, exp_push;
    logic [7:0] exp_val;
    int         exp_lat, exp_cnt;

    localparam logic [25:0] RST_VEC = 26'h2000000;
    logic [25:0] out_vec;
    assign out_vec = {cmd_ready, done, err, result, depth, stk_push, stk_pop, stk_tos, stk_din};

    task automatic do_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_imm = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        ref_stk.delete();
        ref_result = 8'h00;
    endtask

    // Issue one command and record what the DUT does until done (bounded).
    task automatic exec(input logic [2:0] op, input logic [7:0] imm);
        int k, np, npo, nt;
        cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op  = 3'($urandom_range(0, 7));
        cmd_imm = 8'($urandom_range(0, 255));
        np = 0; npo = 0; nt = 0; obs_bad = 1'b0; obs_pdin = 8'h00; obs_trace = '0;
        k = 1;
        while (done !== 1'b1 && k < 12) begin
            if (stk_push) begin np++; obs_pdin = stk_din; end
            if (stk_pop) npo++;
            if (stk_tos) nt++;
            if (int'(stk_push) + int'(stk_pop) + int'(stk_tos) > 1 || (!stk_push && stk_din != 8'h00) || cmd_ready)
                obs_bad = 1'b1;
            if (k < 8) obs_trace[3*k +: 3] = {stk_push, stk_pop, stk_tos};
            @(posedge clk); #1;
            k++;
        end
        if (stk_push || stk_pop || stk_tos) obs_bad = 1'b1;
        obs_lat = (done === 1'b1) ? k : 99;
        obs_err = err;
        obs_cnt = np * 100 + npo * 10 + nt;
    endtask

    // Abstract model: stack as a queue, expected latency and strobe counts per op class.
    task automatic model_cmd(input logic [2:0] op, input logic [7:0] imm);
        int need;
        logic [7:0] a, b;
        need = (op == 3'd0) ? 0 : (op == 3'd1 || op == 3'd2 || op == 3'd7) ? 1 : 2;
        exp_err  = (ref_stk.size() < need) || ((op == 3'd0 || op == 3'd2) && ref_stk.size() == 8);
        exp_push = 1'b0; exp_lat = 1; exp_cnt = 0;
        if (!exp_err) begin
            case (op)
                3'd0: begin exp_val = imm; exp_lat = 2; exp_cnt = 100; end
                3'd1: begin exp_val = ref_stk.pop_back(); exp_lat = 3; exp_cnt = 11; end
                3'd2: begin exp_val = ref_stk[$]; exp_lat = 4; exp_cnt = 101; end
                3'd7: begin a = ref_stk.pop_back(); exp_val = ~a; exp_lat = 4; exp_cnt = 111; end
                default: begin
                    a = ref_stk.pop_back(); b = ref_stk.pop_back();
                    case (op)
                        3'd3:    exp_val = b + a;
                        3'd4:    exp_val = b - a;
                        3'd5:    exp_val = b & a;
                        default: exp_val = b | a;
                    endcase
                    exp_lat = 6; exp_cnt = 122;
                end
            endcase
            if (op != 3'd1) begin ref_stk.push_back(exp_val); exp_push = 1'b1; end
            ref_result = exp_val;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (out_vec !== RST_VEC) begin n_bad++; $display("FAIL reset_state got %h exp %h", out_vec, RST_VEC); end
    endtask

    task automatic test_push_sub();
        logic [23:0] exp_tr;
        do_reset();
        exec(3'd0, 8'h80);
        n_vec++;
        if (obs_lat !== 2 || obs_pdin !== 8'h80 || obs_trace !== 24'h20) begin
            n_bad++; $display("FAIL push80 lat=%0d din=%h tr=%h exp 2/80/000020", obs_lat, obs_pdin, obs_trace);
        end
        exec(3'd0, 8'h55);
        n_vec++;
        if (obs_lat !== 2 || obs_pdin !== 8'h55 || depth !== 4'd2 || result !== 8'h55) begin
            n_bad++; $display("FAIL push55 lat=%0d din=%h depth=%0d res=%h exp 2/55/2/55", obs_lat, obs_pdin, depth, result);
        end
        exec(3'd4, 8'h00);
        exp_tr = 24'({3'b100, 3'b010, 3'b001, 3'b010, 3'b001, 3'b000});
        n_vec++;
        if (obs_trace !== exp_tr) begin n_bad++; $display("FAIL sub_trace got %h exp %h", obs_trace, exp_tr); end
        n_vec++;
        if (obs_lat !== 6 || obs_pdin !== 8'h2B || depth !== 4'd1 || result !== 8'h2B || obs_err !== 1'b0) begin
            n_bad++; $display("FAIL sub lat=%0d din=%h depth=%0d res=%h err=%b exp 6/2b/1/2b/0", obs_lat, obs_pdin, depth, result, obs_err);
        end
    endtask

    task automatic test_add_wrap();
        do_reset();
        exec(3'd0, 8'hFF);
        exec(3'd0, 8'h02);
        exec(3'd3, 8'h00);
        n_vec++;
        if (obs_lat !== 6 || result !== 8'h01 || depth !== 4'd1) begin
            n_bad++; $display("FAIL add_wrap lat=%0d res=%h depth=%0d exp 6/01/1", obs_lat, result, depth);
        end
    endtask

    task automatic test_errors();
        do_reset();
        exec(3'd1, 8'h00);
        n_vec++;
        if (obs_lat !== 1 || obs_err !== 1'b1 || obs_cnt !== 0 || depth !== 4'd0 || result !== 8'h00) begin
            n_bad++; $display("FAIL pop_empty lat=%0d err=%b cnt=%0d depth=%0d exp 1/1/0/0", obs_lat, obs_err, obs_cnt, depth);
        end
        for (int i = 0; i < 8; i++) exec(3'd0, 8'(i + 16));
        exec(3'd2, 8'h00);
        n_vec++;
        if (obs_lat !== 1 || obs_err !== 1'b1 || obs_cnt !== 0 || depth !== 4'd8 || result !== 8'h17) begin
            n_bad++; $display("FAIL dup_full lat=%0d err=%b cnt=%0d depth=%0d res=%h exp 1/1/0/8/17", obs_lat, obs_err, obs_cnt, depth, result);
        end
        exec(3'd0, 8'hAA);
        n_vec++;
        if (obs_err !== 1'b1 || depth !== 4'd8) begin
            n_bad++; $display("FAIL push_full err=%b depth=%0d exp 1/8", obs_err, depth);
        end
    endtask

    task automatic test_dup_not();
        do_reset();
        exec(3'd0, 8'h3C);
        exec(3'd2, 8'h00);
        n_vec++;
        if (obs_lat !== 4 || obs_cnt !== 101 || depth !== 4'd2 || result !== 8'h3C) begin
            n_bad++; $display("FAIL dup lat=%0d cnt=%0d depth=%0d res=%h exp 4/101/2/3c", obs_lat, obs_cnt, depth, result);
        end
        exec(3'd1, 8'h00);
        n_vec++;
        if (obs_lat !== 3 || result !== 8'h3C || depth !== 4'd1) begin
            n_bad++; $display("FAIL pop1 lat=%0d res=%h depth=%0d exp 3/3c/1", obs_lat, result, depth);
        end
        exec(3'd7, 8'h00);
        n_vec++;
        if (obs_lat !== 4 || result !== 8'hC3 || depth !== 4'd1 || obs_cnt !== 111) begin
            n_bad++; $display("FAIL not lat=%0d res=%h depth=%0d cnt=%0d exp 4/c3/1/111", obs_lat, result, depth, obs_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int pushes;
        do_reset();
        exec(3'd0, 8'h01);
        exec(3'd0, 8'h02);
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_imm = 8'h00;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (stk_pop !== 1'b1) begin n_bad++; $display("FAIL midrst_capb pop=%b exp 1", stk_pop); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (out_vec !== RST_VEC) begin n_bad++; $display("FAIL midrst_state got %h exp %h", out_vec, RST_VEC); end
        rst_n = 1'b1;
        pushes = 0;
        repeat (3) begin @(posedge clk); #1; if (stk_push) pushes++; end
        n_vec++;
        if (pushes !== 0 || depth !== 4'd0) begin
            n_bad++; $display("FAIL midrst_nopush pushes=%0d depth=%0d exp 0/0", pushes, depth);
        end
        ref_stk.delete();
        ref_result = 8'h00;
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [7:0] imm;
        int r;
        do_reset();
        for (int i = 0; i < 250; i++) begin
            r   = $urandom_range(0, 9);
            op  = (r > 7) ? 3'd0 : 3'(r);
            imm = 8'($urandom_range(0, 255));
            model_cmd(op, imm);
            exec(op, imm);
            n_vec++;
            if (obs_lat !== exp_lat || obs_err !== exp_err) begin
                n_bad++; $display("FAIL rand_lat i=%0d op=%0d lat=%0d err=%b exp %0d/%b", i, op, obs_lat, obs_err, exp_lat, exp_err);
            end
            n_vec++;
            if (depth !== 4'(ref_stk.size()) || result !== ref_result) begin
                n_bad++; $display("FAIL rand_state i=%0d op=%0d depth=%0d res=%h exp %0d/%h", i, op, depth, result, ref_stk.size(), ref_result);
            end
            n_vec++;
            if (obs_cnt !== exp_cnt || obs_bad !== 1'b0) begin
                n_bad++; $display("FAIL rand_strobes i=%0d op=%0d cnt=%0d bad=%b exp %0d/0", i, op, obs_cnt, obs_bad, exp_cnt);
            end
            if (exp_push) begin
                n_vec++;
                if (obs_pdin !== exp_val) begin
                    n_bad++; $display("FAIL rand_din i=%0d op=%0d din=%h exp %h", i, op, obs_pdin, exp_val);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_imm = 8'd0;
        test_reset();
        test_push_sub();
        test_add_wrap();
        test_errors();
        test_dup_not();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
